// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, UNROLL root bits per RUN cycle, valid/ready on both sides.
// Define ISQRT_REM_EN to expose the final remainder on out_rem.
module isqrt_seq #(
  parameter int WIDTH  = 16,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
`ifdef ISQRT_REM_EN
  output logic [WIDTH/2:0]   out_rem,
`endif
  output logic               busy
);

  localparam int HW    = WIDTH / 2;
  localparam int RMW   = HW + 1;
  localparam int RW    = HW + 2;
  localparam int N     = WIDTH / (2 * UNROLL);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] op_q;
  logic [RMW-1:0]   rem_q;
  logic [HW-1:0]    root_q;
  logic [CNT_W-1:0] cnt_q;
  logic [HW-1:0]    res_root_q;
`ifdef ISQRT_REM_EN
  logic [RMW-1:0]   res_rem_q;
`endif

  logic [WIDTH-1:0] op_nx;
  logic [RMW-1:0]   rem_nx;
  logic [HW-1:0]    root_nx;
  logic [RMW+HW-1:0] step;

  // One restoring digit: bring down the next operand pair and try subtracting 4*root+1.
  // The stored remainder never exceeds 2*root, so RMW bits hold it after either branch.
  function automatic logic [RMW+HW-1:0] root_step(
    input logic [RMW-1:0] rem_i,
    input logic [HW-1:0]  root_i,
    input logic [1:0]     pair
  );
    logic [RW-1:0] r_try;
    logic [RW-1:0] t_try;
    r_try = {rem_i, pair};
    t_try = {root_i, 2'b01};
    if (r_try >= t_try)
      root_step = {RMW'(r_try - t_try), root_i[HW-2:0], 1'b1};
    else
      root_step = {RMW'(r_try), root_i[HW-2:0], 1'b0};
  endfunction

  always_comb begin
    op_nx   = op_q;
    rem_nx  = rem_q;
    root_nx = root_q;
    step    = '0;
    for (int k = 0; k < UNROLL; k++) begin
      step    = root_step(rem_nx, root_nx, op_nx[WIDTH-1 -: 2]);
      rem_nx  = step[RMW+HW-1:HW];
      root_nx = step[HW-1:0];
      op_nx   = op_nx << 2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      res_root_q <= '0;
`ifdef ISQRT_REM_EN
      res_rem_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_data;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          op_q   <= op_nx;
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q    <= S_DONE;
            res_root_q <= root_nx;
`ifdef ISQRT_REM_EN
            res_rem_q  <= rem_nx;
`endif
          end
        end
        S_DONE: begin
          // Result registers are cleared on exit so the outputs read 0 outside DONE.
          if (out_ready) begin
            state_q    <= S_IDLE;
            res_root_q <= '0;
`ifdef ISQRT_REM_EN
            res_rem_q  <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_root  = res_root_q;
`ifdef ISQRT_REM_EN
  assign out_rem   = res_rem_q;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Testbench for isqrt_seq: WIDTH=16/UNROLL=1 and WIDTH=8/UNROLL=2 instances, queue scoreboard.
// Remainder checks are active when ISQRT_REM_EN is defined.
module tb_isqrt_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, busy16;
  logic [15:0] id16 = '0;
  logic [7:0]  root16;
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
  logic [7:0]  id8 = '0;
  logic [3:0]  root8;
`ifdef ISQRT_REM_EN
  logic [8:0]  rem16;
  logic [4:0]  rem8;
`endif

  isqrt_seq #(.WIDTH(16), .UNROLL(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_root(root16),
`ifdef ISQRT_REM_EN
    .out_rem(rem16),
`endif
    .busy(busy16));

  isqrt_seq #(.WIDTH(8), .UNROLL(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_root(root8),
`ifdef ISQRT_REM_EN
    .out_rem(rem8),
`endif
    .busy(busy8));

  logic        sel = 1'b0;
  logic        cur_ir, cur_ov, cur_busy;
  logic [31:0] cur_root, cur_rem;
  assign cur_ir   = sel ? ir8 : ir16;
  assign cur_ov   = sel ? ov8 : ov16;
  assign cur_busy = sel ? busy8 : busy16;
  assign cur_root = sel ? {28'd0, root8} : {24'd0, root16};
`ifdef ISQRT_REM_EN
  assign cur_rem  = sel ? {27'd0, rem8} : {23'd0, rem16};
`else
  assign cur_rem  = '0;
`endif

  typedef struct { logic [31:0] root; logic [31:0] rem; } exp_t;
  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] ref_root(input logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic r);
    if (sel) begin
      iv8 = v; id8 = d[7:0]; or8 = r; iv16 = 1'b0; or16 = 1'b0;
    end else begin
      iv16 = v; id16 = d; or16 = r; iv8 = 1'b0; or8 = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] x);
    exp_t e;
    e.root = ref_root(x);
    e.rem  = x - e.root * e.root;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_root"}, cur_root, e.root);
`ifdef ISQRT_REM_EN
      chk({tag, "_rem"}, cur_rem, e.rem);
`endif
    end
  endtask

  // Directed operation: accept x, check latency, optionally stall in DONE, then drain.
  task automatic do_op(input logic [15:0] x, input int hold);
    int lat;
    int exp_lat;
    exp_lat = sel ? 2 : 8;
    @(negedge clk);
    chk("idle_in_ready", cur_ir, 1);
    set_in(1'b1, x, 1'b0);
    push(sel ? {24'd0, x[7:0]} : {16'd0, x});
    @(negedge clk);
    lat = 0;
    set_in(1'b1, ~x, 1'b0);
    chk("run_busy", cur_busy, 1);
    chk("run_in_ready", cur_ir, 0);
    while (!cur_ov && lat < 40) begin
      @(negedge clk);
      lat++;
      set_in(1'b1, 16'($urandom), 1'b0);
    end
    set_in(1'b0, '0, 1'b0);
    chk("latency", lat, exp_lat);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", cur_ov, 1);
      chk("hold_in_ready", cur_ir, 0);
      if (sb.size() != 0) chk("hold_root", cur_root, sb[0].root);
    end
    set_in(1'b0, '0, 1'b1);
    pop_chk("op");
    @(negedge clk);
    set_in(1'b0, '0, 1'b0);
    chk("post_valid", cur_ov, 0);
    chk("post_in_ready", cur_ir, 1);
    chk("post_root", cur_root, 0);
  endtask

  task automatic run_random(input int nops, input int budget);
    int acc = 0;
    int done_ops = 0;
    int cyc = 0;
    logic v, r;
    logic [15:0] x;
    while (done_ops < nops && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v = (acc < nops) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      set_in(v, x, r);
      if (v && cur_ir) begin
        push(sel ? {24'd0, x[7:0]} : {16'd0, x});
        acc++;
      end
      if (cur_ov && r) begin
        pop_chk("rand");
        done_ops++;
      end
    end
    chk("rand_completed", done_ops, nops);
    @(negedge clk);
    set_in(1'b0, '0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", cur_ir, 1);
      chk("rst_out_valid", cur_ov, 0);
      chk("rst_busy", cur_busy, 0);
      chk("rst_root", cur_root, 0);
`ifdef ISQRT_REM_EN
      chk("rst_rem", cur_rem, 0);
`endif
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd144, 0);
    do_op(16'd145, 0);
    do_op(16'd0, 0);
    do_op(16'd65535, 0);
    do_op(16'd200, 5);

    // Abort in the 4th RUN cycle.
    @(negedge clk);
    set_in(1'b1, 16'd1000, 1'b0);
    @(negedge clk);
    set_in(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", cur_ov, 0);
    chk("abort_in_ready", cur_ir, 1);
    chk("abort_busy", cur_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", cur_ir, 1);
    do_op(16'd81, 0);

    sel = 1'b1;
    do_op(16'd200, 0);
    do_op(16'd255, 2);
    do_op(16'd0, 0);

    sel = 1'b0;
    run_random(2000, 45000);
    sel = 1'b1;
    run_random(2000, 30000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
